i2c_txn_arbiter: RTL and testbench
==================================

# i2c_txn_arbiter

- Shares one `i2c_master` instance between `N_REQ` independent requesters.
- Arbitrates round-robin, latches the winner's address, rw bit and write data, then sequences the master's start/ready handshake.
- Returns read data and a done/error pulse to the winner.
- Supervises each transaction with a timeout. On expiry it resets the master, which otherwise can hang in its ACK-wait states.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 1024: maximum `iw_clk` cycles from start to master idle.
- `RST_CYCLES`, 2: cycles `ow_m_reset` is held on recovery.

- `iw_clk` in 1: system clock; also drives the master.
- `iw_reset_n` in 1: asynchronous, active-low reset.
- `iw_req` in N_REQ: per-requester request, level, held until grant.
- `iw_req_addr` in N_REQ*7: packed slave addresses; requester i uses bits [7i+6:7i].
- `iw_req_rw` in N_REQ: 1 = read, 0 = write.
- `iw_req_wdata` in N_REQ*8: packed write bytes.
- `ow_gnt` in/out: out N_REQ: one-hot, 1-cycle pulse when the request is accepted.
- `ow_done` out N_REQ: one-hot, 1-cycle pulse when the transaction ends.
- `ow_rdata` out 8: read byte; valid only in the `ow_done` cycle.
- `ow_err` out 1: valid with `ow_done`; timeout, or read finished without data.
- `ow_m_start` out 1: to master `iw_start`.
- `ow_m_addr` out 7: to master `iw_addr`.
- `ow_m_rw` out 1: to master `iw_rw`.
- `ow_m_reset` out 1: to master `iw_reset`, synchronous, active-high.
- `io_m_data` inout 8: to master `io_data`. Driven only in ISSUE, high-Z otherwise.
- `iw_m_ready` in 1: master `ow_ready`.
- `iw_m_data_en` in 1: master `ow_data_en`.

## Operation
- States: IDLE, ISSUE, BUSY, RECOVER, RESP. All outputs are registered.
- Reset values (`iw_reset_n` low): state IDLE, rr pointer = N_REQ-1, `ow_gnt`/`ow_done`/`ow_err`/`ow_m_start` = 0, `ow_rdata` = 0. `ow_m_reset` = 1, so the master is held reset. `io_m_data` is high-Z.
- First edge after reset release: `ow_m_reset` drops to 0.
- IDLE:
  - Waits for `|iw_req` and `iw_m_ready`.
  - Winner is the first set bit searching upward from pointer+1, modulo N_REQ.
  - On that edge: latch the winner's addr/rw/wdata, pulse `ow_gnt[winner]`, set pointer = winner, clear the timeout counter, go to ISSUE.
- ISSUE:
  - `ow_m_start` = 1; `io_m_data` is driven with the latched wdata.
  - When `iw_m_ready` is sampled low: drop start, release `io_m_data`, go to BUSY.
- BUSY:
  - On the first edge with `iw_m_data_en` = 1, capture `io_m_data` into `ow_rdata` and set the got_data flag.
  - When `iw_m_ready` returns high, go to RESP.
- RESP:
  - Pulse `ow_done[pointer]`.
  - `ow_err` = timed_out OR (rw AND NOT got_data). A read NACKed on the address phase therefore reports an error.
  - Go to IDLE.
- Timeout:
  - The counter increments in ISSUE and BUSY and saturates.
  - When it reaches TIMEOUT_CYCLES-1: go to RECOVER, set timed_out.
- RECOVER:
  - `ow_m_reset` = 1 for RST_CYCLES cycles, then go to RESP.
- Write transactions never report an ACK error, because the master does not expose one.
- Requests:
  - A requester dropping `iw_req` before grant is legal; no grant is issued.
  - Requests arriving while not IDLE wait.
  - A requester may re-request in the cycle after its `ow_done`. Round-robin then favours other pending requesters.
- Asynchronous reset mid-transaction: immediate return to IDLE with reset values. No `ow_done` is issued for the aborted transaction, and the master is held reset.

## Timing
- Requests sampled at edge t → `ow_gnt` and `ow_m_start` high during t+1.
- The master samples start at t+2; `iw_m_ready` is low after t+2.
- BUSY is entered at edge t+3.
- `ow_done` arrives one cycle after `iw_m_ready` is sampled high in BUSY.
- Back-to-back: the next `ow_gnt` comes at the earliest in the cycle after `ow_done`.
- Bus turnaround: `io_m_data` is released in the same edge that leaves ISSUE. The master drives it only after `ow_data_en`, i.e. at least 10 cycles later, so the bus is never driven by both sides at once.
- Timeout latency: `ow_done` arrives TIMEOUT_CYCLES + RST_CYCLES + 1 cycles after the ISSUE entry.

## Structure
- Shared package `i2c_pkg`:
  - `I2C_ADDR_W` = 7, `I2C_DATA_W` = 8.
  - Arbiter state encodings.
  - Master state encodings, so both blocks take them from one place.
- Sub-module `rr_arbiter`:
  - Parameter N.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, winner index, any.
  - Combinational; the pointer register stays in `i2c_txn_arbiter`.
- Top-level tristate of `io_m_data` and the master's pullups stay in the integrating module.

## Test plan
- Single write, req0, addr 0x50, data 0xA5, slave ACKs → `ow_gnt` = 0001 at t+1, `ow_done` = 0001, `ow_err` = 0; bus carries 0xA0 then 0xA5.
- Single read, req2, addr 0x3C, slave returns 0x5A → `ow_done` = 0100, `ow_rdata` = 0x5A, `ow_err` = 0.
- Read NACKed on address → `ow_done` pulse, `ow_err` = 1, `ow_rdata` is don't-care.
- All four requests held continuously → grant order 0, 1, 2, 3, 0, …, one transaction at a time; `ow_m_start` never asserted while `iw_m_ready` = 0 outside ISSUE.
- Write with the slave withholding the data ACK, TIMEOUT_CYCLES = 64 → `ow_m_reset` high for 2 cycles, then `ow_done` with `ow_err` = 1 at cycle 67 after ISSUE. A following request completes normally.
- `iw_reset_n` pulled low mid-read → `ow_m_reset` = 1 and all pulses 0 immediately. After release: `ow_m_reset` = 0 next edge, no stale `ow_done`, and a new grant works.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus widths plus the state encodings of the
// transaction arbiter and of the bit-level master it drives.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_BUSY,
    ARB_RECOVER,
    ARB_RESP
  } arb_state_e;

  typedef enum logic [3:0] {
    M_IDLE,
    M_START,
    M_ADDR,
    M_ADDR_ACK,
    M_WRITE,
    M_WRITE_ACK,
    M_READ,
    M_READ_ACK,
    M_STOP
  } m_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the slot after i_ptr has top priority,
// wrapping modulo N. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  // Walk the N slots upward from i_ptr+1 and keep the first requester found
  always_comb begin
    logic [PW:0] w_slot;
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_slot = '0;
    for (int k = 1; k <= N; k++) begin
      w_slot = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_slot >= (PW+1)'(N)) begin
        w_slot = w_slot - (PW+1)'(N);
      end
      if (!o_any && i_req[w_slot[PW-1:0]]) begin
        o_any               = 1'b1;
        o_idx               = w_slot[PW-1:0];
        o_gnt[w_slot[PW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master between N_REQ requesters: round-robin grant,
// start/ready handshake, read-data return and a timeout that resets a hung
// master. Every output comes straight from a register.
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int RST_CYCLES     = 2
) (
  input  logic                        iw_clk,
  input  logic                        iw_reset_n,
  input  logic [N_REQ-1:0]            iw_req,
  input  logic [N_REQ*I2C_ADDR_W-1:0] iw_req_addr,
  input  logic [N_REQ-1:0]            iw_req_rw,
  input  logic [N_REQ*I2C_DATA_W-1:0] iw_req_wdata,
  output logic [N_REQ-1:0]            ow_gnt,
  output logic [N_REQ-1:0]            ow_done,
  output logic [I2C_DATA_W-1:0]       ow_rdata,
  output logic                        ow_err,
  output logic                        ow_m_start,
  output logic [I2C_ADDR_W-1:0]       ow_m_addr,
  output logic                        ow_m_rw,
  output logic                        ow_m_reset,
  inout  wire  [I2C_DATA_W-1:0]       io_m_data,
  input  logic                        iw_m_ready,
  input  logic                        iw_m_data_en
);

  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);

  arb_state_e            r_state,     w_state_nx;
  logic [PW-1:0]         r_ptr,       w_ptr_nx;
  logic [I2C_ADDR_W-1:0] r_addr,      w_addr_nx;
  logic                  r_rw,        w_rw_nx;
  logic [I2C_DATA_W-1:0] r_wdata,     w_wdata_nx;
  logic [N_REQ-1:0]      r_gnt,       w_gnt_nx;
  logic [N_REQ-1:0]      r_done,      w_done_nx;
  logic                  r_err,       w_err_nx;
  logic [I2C_DATA_W-1:0] r_rdata,     w_rdata_nx;
  logic                  r_start,     w_start_nx;
  logic                  r_mreset,    w_mreset_nx;
  logic                  r_drive,     w_drive_nx;
  logic [TW-1:0]         r_tcnt,      w_tcnt_nx;
  logic                  r_timed_out, w_timed_out_nx;
  logic                  r_got_data,  w_got_data_nx;
  logic [RW-1:0]         r_rcnt,      w_rcnt_nx;

  logic [N_REQ-1:0]      w_arb_gnt;
  logic [PW-1:0]         w_arb_idx;
  logic                  w_arb_any;
  logic [I2C_ADDR_W-1:0] w_sel_addr;
  logic                  w_sel_rw;
  logic [I2C_DATA_W-1:0] w_sel_wdata;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .i_req (iw_req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  // Pick the winning requester's address, direction and write byte
  always_comb begin
    w_sel_addr  = '0;
    w_sel_rw    = 1'b0;
    w_sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_arb_idx == PW'(i)) begin
        w_sel_addr  = iw_req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
        w_sel_rw    = iw_req_rw[i];
        w_sel_wdata = iw_req_wdata[i*I2C_DATA_W +: I2C_DATA_W];
      end
    end
  end

  // Next-state and next-output logic; pulses and master reset default low
  always_comb begin
    w_state_nx     = r_state;
    w_ptr_nx       = r_ptr;
    w_addr_nx      = r_addr;
    w_rw_nx        = r_rw;
    w_wdata_nx     = r_wdata;
    w_gnt_nx       = '0;
    w_done_nx      = '0;
    w_err_nx       = 1'b0;
    w_rdata_nx     = r_rdata;
    w_start_nx     = r_start;
    w_mreset_nx    = 1'b0;
    w_drive_nx     = r_drive;
    w_tcnt_nx      = r_tcnt;
    w_timed_out_nx = r_timed_out;
    w_got_data_nx  = r_got_data;
    w_rcnt_nx      = r_rcnt;
    case (r_state)
      ARB_IDLE: begin
        if (w_arb_any && iw_m_ready) begin
          w_addr_nx      = w_sel_addr;
          w_rw_nx        = w_sel_rw;
          w_wdata_nx     = w_sel_wdata;
          w_gnt_nx       = w_arb_gnt;
          w_ptr_nx       = w_arb_idx;
          w_tcnt_nx      = '0;
          w_timed_out_nx = 1'b0;
          w_got_data_nx  = 1'b0;
          w_start_nx     = 1'b1;
          w_drive_nx     = 1'b1;
          w_state_nx     = ARB_ISSUE;
        end
      end
      ARB_ISSUE, ARB_BUSY: begin
        if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          w_state_nx     = ARB_RECOVER;
          w_timed_out_nx = 1'b1;
          w_mreset_nx    = 1'b1;
          w_start_nx     = 1'b0;
          w_drive_nx     = 1'b0;
          w_rcnt_nx      = '0;
        end else begin
          w_tcnt_nx = r_tcnt + TW'(1);
          if (r_state == ARB_ISSUE) begin
            if (!iw_m_ready) begin
              w_start_nx = 1'b0;
              w_drive_nx = 1'b0;
              w_state_nx = ARB_BUSY;
            end
          end else begin
            if (iw_m_data_en && !r_got_data) begin
              w_rdata_nx    = io_m_data;
              w_got_data_nx = 1'b1;
            end
            if (iw_m_ready) begin
              w_state_nx = ARB_RESP;
            end
          end
        end
      end
      ARB_RECOVER: begin
        if (r_rcnt == RW'(RST_CYCLES - 1)) begin
          w_state_nx = ARB_RESP;
        end else begin
          w_mreset_nx = 1'b1;
          w_rcnt_nx   = r_rcnt + RW'(1);
        end
      end
      ARB_RESP: begin
        w_done_nx[r_ptr] = 1'b1;
        w_err_nx         = r_timed_out | (r_rw & ~r_got_data);
        w_state_nx       = ARB_IDLE;
      end
      default: w_state_nx = ARB_IDLE;
    endcase
  end

  // State and output registers; reset parks the master in reset
  always_ff @(posedge iw_clk or negedge iw_reset_n) begin
    if (!iw_reset_n) begin
      r_state     <= ARB_IDLE;
      r_ptr       <= PW'(N_REQ - 1);
      r_addr      <= '0;
      r_rw        <= 1'b0;
      r_wdata     <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_start     <= 1'b0;
      r_mreset    <= 1'b1;
      r_drive     <= 1'b0;
      r_tcnt      <= '0;
      r_timed_out <= 1'b0;
      r_got_data  <= 1'b0;
      r_rcnt      <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_ptr       <= w_ptr_nx;
      r_addr      <= w_addr_nx;
      r_rw        <= w_rw_nx;
      r_wdata     <= w_wdata_nx;
      r_gnt       <= w_gnt_nx;
      r_done      <= w_done_nx;
      r_err       <= w_err_nx;
      r_rdata     <= w_rdata_nx;
      r_start     <= w_start_nx;
      r_mreset    <= w_mreset_nx;
      r_drive     <= w_drive_nx;
      r_tcnt      <= w_tcnt_nx;
      r_timed_out <= w_timed_out_nx;
      r_got_data  <= w_got_data_nx;
      r_rcnt      <= w_rcnt_nx;
    end
  end

  assign ow_gnt     = r_gnt;
  assign ow_done    = r_done;
  assign ow_err     = r_err;
  assign ow_rdata   = r_rdata;
  assign ow_m_start = r_start;
  assign ow_m_addr  = r_addr;
  assign ow_m_rw    = r_rw;
  assign ow_m_reset = r_mreset;
  assign io_m_data  = r_drive ? r_wdata : 'z;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: a cycle-level master model plus a transaction
// model (round-robin winner, latency, error and read data per transaction).
module tb_i2c_txn_arbiter;

  localparam int NREQ = 4;
  localparam int TOUT = 64;
  localparam int RSTC = 2;

  logic clk = 1'b0;
  logic rstN;
  logic [NREQ-1:0]   req;
  logic [NREQ*7-1:0] reqAddr;
  logic [NREQ-1:0]   reqRw;
  logic [NREQ*8-1:0] reqWdata;
  wire  [NREQ-1:0]   gnt;
  wire  [NREQ-1:0]   done;
  wire  [7:0]        rdata;
  wire               err;
  wire               mStart;
  wire  [6:0]        mAddr;
  wire               mRw;
  wire               mReset;
  wire  [7:0]        ioData;

  logic       mReady  = 1'b1;
  logic       mDataEn = 1'b0;
  logic       mDrive  = 1'b0;
  logic       mBusy   = 1'b0;
  int         mCnt    = 0;
  logic [7:0] mRdata;
  int         cfgLen, cfgDataAt;
  bit         cfgGive, cfgHang;

  int assertCount = 0;
  int failCount   = 0;
  int ptrModel;

  always #5 clk = ~clk;

  assign ioData = mDrive ? mRdata : 8'hzz;

  i2c_txn_arbiter #(
    .N_REQ(NREQ), .TIMEOUT_CYCLES(TOUT), .RST_CYCLES(RSTC)
  ) dut (
    .iw_clk(clk), .iw_reset_n(rstN), .iw_req(req), .iw_req_addr(reqAddr),
    .iw_req_rw(reqRw), .iw_req_wdata(reqWdata), .ow_gnt(gnt), .ow_done(done),
    .ow_rdata(rdata), .ow_err(err), .ow_m_start(mStart), .ow_m_addr(mAddr),
    .ow_m_rw(mRw), .ow_m_reset(mReset), .io_m_data(ioData),
    .iw_m_ready(mReady), .iw_m_data_en(mDataEn)
  );

  // Master model: accepts start when ready, stays busy cfgLen+1 cycles, optionally pulses data_en
  always @(posedge clk) begin
    if (!rstN || mReset) begin
      mReady <= 1'b1; mDataEn <= 1'b0; mDrive <= 1'b0; mBusy <= 1'b0; mCnt <= 0;
    end else if (!mBusy) begin
      mDataEn <= 1'b0; mDrive <= 1'b0;
      if (mStart && mReady) begin
        mReady <= 1'b0; mBusy <= 1'b1; mCnt <= 0;
      end
    end else begin
      mCnt <= mCnt + 1; mDataEn <= 1'b0; mDrive <= 1'b0;
      if (cfgGive && mCnt == cfgDataAt) begin
        mDataEn <= 1'b1; mDrive <= 1'b1;
      end
      if (!cfgHang && mCnt == cfgLen) begin
        mReady <= 1'b1; mBusy <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    reqAddr[i*7 +: 7]  = a;
    reqRw[i]           = rw;
    reqWdata[i*8 +: 8] = wd;
  endtask

  // First pending requester strictly after the last winner, wrapping around
  function automatic int expWinner(input logic [NREQ-1:0] r, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      int idx = (p + k) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // Runs one transaction end to end and checks it against the transaction model
  task automatic serveOne(input int len, input int dataAt, input bit give, input bit hang,
                          input logic [7:0] rd, input bit keep);
    int   w, c, rstCycles;
    bit   seen;
    logic expRw;
    cfgLen = len; cfgDataAt = dataAt; cfgGive = give; cfgHang = hang; mRdata = rd;
    w = expWinner(req, ptrModel);
    tick();
    checkOutput("done_pulse_width", 32'(done), 0);
    c = 0; seen = 0;
    while (!seen && c < 30) begin
      if (gnt != '0) seen = 1;
      else begin tick(); c++; end
    end
    if (!seen || w < 0) begin
      checkOutput("gnt_timeout", 0, 1);
      return;
    end
    checkOutput("gnt_onehot", 32'(gnt), 32'(1) << w);
    checkOutput("m_start", 32'(mStart), 1);
    checkOutput("m_addr", 32'(mAddr), 32'(reqAddr[w*7 +: 7]));
    checkOutput("m_rw", 32'(mRw), 32'(reqRw[w]));
    checkOutput("bus_wdata", 32'(ioData), 32'(reqWdata[w*8 +: 8]));
    expRw = reqRw[w];
    ptrModel = w;
    if (!keep) req[w] = 1'b0;
    c = 0; rstCycles = 0; seen = 0;
    while (!seen && c < 2000) begin
      tick(); c++;
      if (c == 1) checkOutput("gnt_pulse_width", 32'(gnt), 0);
      if (c == 1) checkOutput("start_held", 32'(mStart), 1);
      if (c == 2) checkOutput("start_dropped", 32'(mStart), 0);
      if (mReset) rstCycles++;
      if (mDrive) checkOutput("bus_turnaround", 32'(ioData), 32'(rd));
      if (done != '0) seen = 1;
    end
    if (!seen) begin
      checkOutput("done_timeout", 0, 1);
      return;
    end
    checkOutput("done_latency", c, hang ? TOUT + RSTC + 1 : len + 4);
    checkOutput("done_onehot", 32'(done), 32'(1) << w);
    checkOutput("err", 32'(err), 32'(hang || (expRw && !give)));
    if (expRw && give && !hang) checkOutput("rdata", 32'(rdata), 32'(rd));
    checkOutput("m_reset_cycles", rstCycles, hang ? RSTC : 0);
  endtask

  initial begin
    int   c, w, len;
    bit   seen, give;
    logic [NREQ-1:0] doneSeen;

    rstN = 1'b0; req = '0; reqAddr = '0; reqRw = '0; reqWdata = '0;
    cfgLen = 20; cfgDataAt = 10; cfgGive = 0; cfgHang = 0; mRdata = 8'h00;
    ptrModel = NREQ - 1;
    tick(); tick();
    checkOutput("reset_m_reset", 32'(mReset), 1);
    checkOutput("reset_gnt", 32'(gnt), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_err", 32'(err), 0);
    checkOutput("reset_start", 32'(mStart), 0);
    checkOutput("reset_rdata", 32'(rdata), 0);
    rstN = 1'b1;
    tick();
    checkOutput("release_m_reset", 32'(mReset), 0);

    $display("[TB] single write req0 addr 0x50 data 0xA5");
    applyStimulus(0, 7'h50, 1'b0, 8'hA5);
    req = 4'b0001;
    serveOne(20, 10, 0, 0, 8'h00, 0);

    $display("[TB] single read req2 addr 0x3C returns 0x5A");
    applyStimulus(2, 7'h3C, 1'b1, 8'h00);
    req = 4'b0100;
    serveOne(30, 15, 1, 0, 8'h5A, 0);

    $display("[TB] read NACKed on address");
    applyStimulus(1, 7'h22, 1'b1, 8'h11);
    req = 4'b0010;
    serveOne(12, 10, 0, 0, 8'h00, 0);

    $display("[TB] all four requests held");
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 7'($urandom), 1'($urandom), 8'($urandom));
    req = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      w = expWinner(req, ptrModel);
      serveOne(14, 10, reqRw[w], 0, 8'($urandom), 1);
    end
    req = '0;

    $display("[TB] write with withheld data ACK times out");
    applyStimulus(3, 7'h44, 1'b0, 8'h3C);
    req = 4'b1000;
    serveOne(0, 0, 0, 1, 8'h00, 0);
    applyStimulus(0, 7'h10, 1'b1, 8'h00);
    req = 4'b0001;
    serveOne(16, 11, 1, 0, 8'hC3, 0);

    $display("[TB] reset pulled mid-read");
    applyStimulus(2, 7'h3C, 1'b1, 8'h00);
    req = 4'b0100;
    cfgLen = 40; cfgDataAt = 30; cfgGive = 1; cfgHang = 0; mRdata = 8'h77;
    c = 0; seen = 0;
    while (!seen && c < 30) begin
      tick(); c++;
      if (gnt != '0) seen = 1;
    end
    checkOutput("abort_gnt_seen", 32'(seen), 1);
    req = '0;
    repeat (8) tick();
    #2 rstN = 1'b0;
    #1;
    checkOutput("abort_m_reset", 32'(mReset), 1);
    checkOutput("abort_gnt", 32'(gnt), 0);
    checkOutput("abort_done", 32'(done), 0);
    checkOutput("abort_start", 32'(mStart), 0);
    tick();
    rstN = 1'b1;
    ptrModel = NREQ - 1;
    tick();
    checkOutput("abort_release_m_reset", 32'(mReset), 0);
    doneSeen = '0;
    repeat (6) begin tick(); doneSeen |= done; end
    checkOutput("abort_no_stale_done", 32'(doneSeen), 0);
    applyStimulus(1, 7'h2B, 1'b0, 8'h96);
    applyStimulus(3, 7'h61, 1'b1, 8'h00);
    req = 4'b1010;
    serveOne(18, 10, 0, 0, 8'h00, 0);
    serveOne(22, 12, 1, 0, 8'hE1, 0);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) applyStimulus(i, 7'($urandom), 1'($urandom), 8'($urandom));
      end
      req = req | 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req[$urandom_range(0, NREQ-1)] = 1'b0;
      if (req == '0) req[$urandom_range(0, NREQ-1)] = 1'b1;
      w    = expWinner(req, ptrModel);
      len  = $urandom_range(12, 40);
      give = reqRw[w] && ($urandom_range(0, 3) != 0);
      serveOne(len, $urandom_range(10, len - 1), give, 0, 8'($urandom), 1'($urandom));
    end
    req = '0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
